dds_wave_ctrl: RTL and testbench

- Consumes the single-cycle debounced key pulses from the per-key debounce stages and maintains the DDS generator's configuration registers.
- Outputs the waveform select, the frequency tuning word, and the current step index. These feed the DDS phase accumulator and the waveform ROM address mux.
- One instance per board, in the sys_clk domain (50 MHz).

---
 rtl/dds_wave_ctrl.sv | 111 +++++++++++
 tb/tb_dds_wave_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_wave_ctrl.sv
// DDS configuration register block: turns debounced key pulses into waveform select,
// frequency tuning word and step index for the phase accumulator and waveform ROM mux.
module dds_wave_ctrl #(
  parameter int              FW_W      = 32,
  parameter logic [FW_W-1:0] FREQ_INIT = 32'd85_899,
  parameter logic [FW_W-1:0] FREQ_MIN  = 32'd86,
  parameter logic [FW_W-1:0] FREQ_MAX  = 32'd85_899_346,
  parameter logic [FW_W-1:0] STEP0     = 32'd86,
  parameter logic [FW_W-1:0] STEP1     = 32'd859,
  parameter logic [FW_W-1:0] STEP2     = 32'd8_590,
  parameter logic [FW_W-1:0] STEP3     = 32'd85_899
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            key_wave,
  input  logic            key_up,
  input  logic            key_dn,
  input  logic            key_step,
  output logic [2:0]      wave_sel,
  output logic [FW_W-1:0] freq_word,
  output logic [1:0]      step_sel,
  output logic            cfg_valid
);

  // Waveform FSM; the state register drives wave_sel directly, so the state is observable.
  typedef enum logic [2:0] {
    WAVE_SINE     = 3'd0,
    WAVE_SQUARE   = 3'd1,
    WAVE_TRIANGLE = 3'd2,
    WAVE_SAWTOOTH = 3'd3,
    WAVE_OFF      = 3'd4
  } wave_e;

  wave_e           wave_q, wave_d;
  logic [1:0]      step_q, step_d;
  logic [FW_W-1:0] freq_q, freq_d;
  logic            valid_q, valid_d;

  logic [FW_W-1:0] step_val;
  logic [FW_W:0]   sum_w;
  logic [FW_W:0]   floor_w;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wave_q  <= WAVE_SINE;
      step_q  <= 2'd0;
      freq_q  <= FREQ_INIT;
      valid_q <= 1'b0;
    end else begin
      wave_q  <= wave_d;
      step_q  <= step_d;
      freq_q  <= freq_d;
      valid_q <= valid_d;
    end
  end

  // Illegal codes 5..7 fall to the default arm and recover to SINE on the next edge.
  always_comb begin
    wave_d = WAVE_SINE;
    case (wave_q)
      WAVE_SINE:     wave_d = key_wave ? WAVE_SQUARE   : WAVE_SINE;
      WAVE_SQUARE:   wave_d = key_wave ? WAVE_TRIANGLE : WAVE_SQUARE;
      WAVE_TRIANGLE: wave_d = key_wave ? WAVE_SAWTOOTH : WAVE_TRIANGLE;
      WAVE_SAWTOOTH: wave_d = key_wave ? WAVE_OFF      : WAVE_SAWTOOTH;
      WAVE_OFF:      wave_d = key_wave ? WAVE_SINE     : WAVE_OFF;
      default:       wave_d = WAVE_SINE;
    endcase
  end

  always_comb begin
    step_d = step_q;
    if (key_step) begin
      step_d = step_q + 2'd1;
    end
  end

  // The step used for this edge is the one registered before it.
  always_comb begin
    step_val = STEP0;
    case (step_q)
      2'd0:    step_val = STEP0;
      2'd1:    step_val = STEP1;
      2'd2:    step_val = STEP2;
      default: step_val = STEP3;
    endcase
  end

  // One extra bit keeps both the sum and the lower bound free of wrap-around.
  assign sum_w   = {1'b0, freq_q} + {1'b0, step_val};
  assign floor_w = {1'b0, step_val} + {1'b0, FREQ_MIN};

  always_comb begin
    freq_d = freq_q;
    if (key_up && !key_dn) begin
      freq_d = (sum_w > {1'b0, FREQ_MAX}) ? FREQ_MAX : sum_w[FW_W-1:0];
    end else if (key_dn && !key_up) begin
      freq_d = ({1'b0, freq_q} < floor_w) ? FREQ_MIN : (freq_q - step_val);
    end
  end

  // cfg_valid: single-cycle strobe, high in the cycle after any output register changed.
  always_comb begin
    valid_d = (wave_d != wave_q) || (step_d != step_q) || (freq_d != freq_q);
  end

  assign wave_sel  = wave_q;
  assign freq_word = freq_q;
  assign step_sel  = step_q;
  assign cfg_valid = valid_q;

endmodule

// File: tb/tb_dds_wave_ctrl.sv
// Self-checking bench for dds_wave_ctrl: vector table, hand sequences for the corner
// cases, and random key traffic checked against an arithmetic reference model.
module tb_dds_wave_ctrl;

  localparam int     FW_W      = 32;
  localparam longint FREQ_INIT = 85_899;
  localparam longint FREQ_MIN  = 86;
  localparam longint FREQ_MAX  = 85_899_346;

  logic            sys_clk = 1'b0;
  logic            sys_rst_n;
  logic            key_wave, key_up, key_dn, key_step;
  logic [2:0]      wave_sel;
  logic [FW_W-1:0] freq_word;
  logic [1:0]      step_sel;
  logic            cfg_valid;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integers, updated with modular / min-max arithmetic.
  int     m_wave;
  int     m_step;
  longint m_freq;
  longint step_tab[4] = '{86, 859, 8_590, 85_899};

  typedef struct {
    bit     w, u, d, s;
    int     e_wave;
    longint e_freq;
    int     e_step;
    bit     e_valid;
  } vec_t;

  vec_t vecs[15];

  dds_wave_ctrl dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_wave  (key_wave),
    .key_up    (key_up),
    .key_dn    (key_dn),
    .key_step  (key_step),
    .wave_sel  (wave_sel),
    .freq_word (freq_word),
    .step_sel  (step_sel),
    .cfg_valid (cfg_valid)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wave = 0;
    m_step = 0;
    m_freq = FREQ_INIT;
  endtask

  task automatic model_apply(input bit w, u, d, s, output bit ev);
    int     ow, os;
    longint of, st;
    ow = m_wave; os = m_step; of = m_freq;
    st = step_tab[m_step];
    if (w) m_wave = (m_wave + 1) % 5;
    if (s) m_step = (m_step + 1) % 4;
    if (u && !d) m_freq = (of + st > FREQ_MAX) ? FREQ_MAX : of + st;
    if (d && !u) m_freq = (of - st < FREQ_MIN) ? FREQ_MIN : of - st;
    ev = (ow != m_wave) || (os != m_step) || (of != m_freq);
  endtask

  // Drive one cycle of pulses on the falling edge, sample 1 ns after the rising edge.
  task automatic cycle(input bit w, u, d, s, output bit ev);
    @(negedge sys_clk);
    key_wave = w; key_up = u; key_dn = d; key_step = s;
    @(posedge sys_clk);
    #1;
    key_wave = 1'b0; key_up = 1'b0; key_dn = 1'b0; key_step = 1'b0;
    model_apply(w, u, d, s, ev);
  endtask

  task automatic check_model(input string tag, input bit ev);
    chk({tag, ".wave"},  wave_sel,  m_wave);
    chk({tag, ".freq"},  freq_word, m_freq);
    chk({tag, ".step"},  step_sel,  m_step);
    chk({tag, ".valid"}, cfg_valid, ev);
  endtask

  task automatic step_model(input bit w, u, d, s, input string tag);
    bit ev;
    cycle(w, u, d, s, ev);
    check_model(tag, ev);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    key_wave = 1'b0; key_up = 1'b0; key_dn = 1'b0; key_step = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();
  endtask

  function automatic vec_t mk(bit w, u, d, s, int ew, longint ef, int es, bit ev);
    vec_t v;
    v.w = w; v.u = u; v.d = d; v.s = s;
    v.e_wave = ew; v.e_freq = ef; v.e_step = es; v.e_valid = ev;
    return v;
  endfunction

  initial begin
    bit ev;
    sys_rst_n = 1'b0;
    key_wave = 1'b0; key_up = 1'b0; key_dn = 1'b0; key_step = 1'b0;
    model_reset();

    vecs[0]  = mk(0, 0, 0, 0, 0, 85_899, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 1, 85_899, 0, 1);
    vecs[2]  = mk(0, 0, 0, 1, 1, 85_899, 1, 1);
    vecs[3]  = mk(0, 1, 0, 0, 1, 86_758, 1, 1);
    vecs[4]  = mk(0, 0, 1, 0, 1, 85_899, 1, 1);
    vecs[5]  = mk(0, 1, 1, 0, 1, 85_899, 1, 0);
    vecs[6]  = mk(1, 1, 1, 0, 2, 85_899, 1, 1);
    vecs[7]  = mk(0, 1, 0, 1, 2, 86_758, 2, 1);
    vecs[8]  = mk(0, 0, 0, 1, 2, 86_758, 3, 1);
    vecs[9]  = mk(0, 0, 1, 0, 2, 859,    3, 1);
    vecs[10] = mk(0, 0, 1, 0, 2, 86,     3, 1);
    vecs[11] = mk(0, 0, 1, 0, 2, 86,     3, 0);
    vecs[12] = mk(1, 1, 0, 1, 3, 85_985, 0, 1);
    vecs[13] = mk(1, 0, 0, 0, 4, 85_985, 0, 1);
    vecs[14] = mk(1, 0, 0, 0, 0, 85_985, 0, 1);

    // Reset held, then idle for 10 cycles.
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst.wave", wave_sel, 0);
    chk("rst.freq", freq_word, FREQ_INIT);
    chk("rst.step", step_sel, 0);
    chk("rst.valid", cfg_valid, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step_model(0, 0, 0, 0, "idle");

    // Table vectors, applied back to back from the reset state.
    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].w, vecs[i].u, vecs[i].d, vecs[i].s, ev);
      chk($sformatf("vec%0d.wave", i),  wave_sel,  vecs[i].e_wave);
      chk($sformatf("vec%0d.freq", i),  freq_word, vecs[i].e_freq);
      chk($sformatf("vec%0d.step", i),  step_sel,  vecs[i].e_step);
      chk($sformatf("vec%0d.valid", i), cfg_valid, vecs[i].e_valid);
    end

    // Five spaced waveform pulses walk the full ring and come back to SINE.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 0, ev);
      chk("ring.wave", wave_sel, (i + 1) % 5);
      chk("ring.valid", cfg_valid, 1);
      step_model(0, 0, 0, 0, "ring.gap");
      step_model(0, 0, 0, 0, "ring.gap");
    end

    // Coarsest step: two increments, then the step index wraps.
    do_reset();
    repeat (3) step_model(0, 0, 0, 1, "stp");
    repeat (2) step_model(0, 1, 0, 0, "stp.up");
    chk("stp.freq257697", freq_word, 257_697);
    chk("stp.sel3", step_sel, 3);
    step_model(0, 0, 0, 1, "stp.wrap");
    chk("stp.sel0", step_sel, 0);

    // Decrement below the floor clamps, then holds without a strobe.
    do_reset();
    repeat (3) step_model(0, 0, 0, 1, "dn");
    cycle(0, 0, 1, 0, ev);
    chk("dn.clamp.freq", freq_word, FREQ_MIN);
    chk("dn.clamp.valid", cfg_valid, 1);
    cycle(0, 0, 1, 0, ev);
    chk("dn.hold.freq", freq_word, FREQ_MIN);
    chk("dn.hold.valid", cfg_valid, 0);

    // Ramp to just below the ceiling (key_up held = one event per cycle), then clamp.
    do_reset();
    repeat (3) step_model(0, 0, 0, 1, "top");
    for (int i = 0; i < 999; i++) step_model(0, 1, 0, 0, "top.ramp");
    chk("top.near", freq_word, 85_899_000);
    cycle(0, 1, 0, 0, ev);
    chk("top.clamp.freq", freq_word, FREQ_MAX);
    chk("top.clamp.valid", cfg_valid, 1);
    cycle(0, 1, 0, 0, ev);
    chk("top.hold.freq", freq_word, FREQ_MAX);
    chk("top.hold.valid", cfg_valid, 0);

    // Asynchronous reset mid-sequence, between clock edges.
    step_model(1, 0, 0, 1, "arst.pre");
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("arst.wave", wave_sel, 0);
    chk("arst.freq", freq_word, FREQ_INIT);
    chk("arst.step", step_sel, 0);
    chk("arst.valid", cfg_valid, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();
    cycle(0, 1, 0, 0, ev);
    chk("arst.first.freq", freq_word, FREQ_INIT + 86);
    chk("arst.first.valid", cfg_valid, 1);

    // Random key traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step_model($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
